// File: rtl/div_bcd_out.sv
// Sequential double-dabble converter: the div_16bit quotient and remainder become 5-digit packed BCD.
// Optional leading-zero mask on the quotient (q_blank) is enabled by defining DIV_BCD_BLANK_EN.
module div_bcd_out #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     result,
  input  logic [DATA_W-1:0]     odd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd
`ifdef DIV_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     q_blank
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  qs, rs;
  logic [BCD_W-1:0]   qa, ra;
  logic [BCD_W-1:0]   q_corr, r_corr;
  logic [BCD_W-1:0]   qa_nxt, ra_nxt;
  logic [DATA_W-1:0]  qs_nxt, rs_nxt;

  // Digits at 5 or above get +3 so the following shift carries correctly into the next decade.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] res;
    logic [3:0]       d;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = a[4*i +: 4];
      res[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    return res;
  endfunction

`ifdef DIV_BCD_BLANK_EN
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] q);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (q[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction
`endif

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    q_corr = add3(qa);
    r_corr = add3(ra);
    qa_nxt = {q_corr[BCD_W-2:0], qs[DATA_W-1]};
    ra_nxt = {r_corr[BCD_W-2:0], rs[DATA_W-1]};
    qs_nxt = {qs[DATA_W-2:0], 1'b0};
    rs_nxt = {rs[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      qs        <= '0;
      rs        <= '0;
      qa        <= '0;
      ra        <= '0;
      q_bcd     <= '0;
      r_bcd     <= '0;
      out_valid <= 1'b0;
`ifdef DIV_BCD_BLANK_EN
      q_blank   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            qs    <= result;
            rs    <= odd;
            qa    <= '0;
            ra    <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          qs  <= qs_nxt;
          rs  <= rs_nxt;
          qa  <= qa_nxt;
          ra  <= ra_nxt;
          cnt <= cnt + 1'b1;
          // Last shift: publish results directly from the combinational next values.
          if (cnt == CNT_LAST) begin
            q_bcd     <= qa_nxt;
            r_bcd     <= ra_nxt;
            out_valid <= 1'b1;
`ifdef DIV_BCD_BLANK_EN
            q_blank   <= blank_mask(qa_nxt);
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_out.sv
// Directed + random bench for div_bcd_out with a queue scoreboard of expected BCD pairs.
module tb_div_bcd_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic [15:0] odd;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] q_bcd;
  logic [19:0] r_bcd;
`ifdef DIV_BCD_BLANK_EN
  logic [4:0]  q_blank;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          acc_cyc = 0;
  int          lat;
  logic [39:0] sb[$];

  always #5 clk = ~clk;

  div_bcd_out #(.DATA_W(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .odd       (odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd)
`ifdef DIV_BCD_BLANK_EN
    ,
    .q_blank   (q_blank)
`endif
  );

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] blank_model(input int v);
    logic [4:0] m;
    int         p;
    m = '0;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int b);
    result   = 16'(a);
    odd      = 16'(b);
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !in_ready; n++) step();
    check("in_ready_wait", 32'(in_ready), 32'd1);
    step();
    acc_cyc  = cycle;
    sb.push_back({to_bcd(a), to_bcd(b)});
    in_valid = 1'b0;
  endtask

  task automatic receive(input string tag, output int latency);
    logic [39:0] e;
    for (int n = 0; n < 200 && !out_valid; n++) step();
    latency = cycle - acc_cyc;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 40'hFFFFFFFFFF;
    check({tag, "_q"}, 32'(q_bcd), 32'(e[39:20]));
    check({tag, "_r"}, 32'(r_bcd), 32'(e[19:0]));
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    int a, b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    result    = '0;
    odd       = '0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q_bcd), 32'd0);
    check("rst_r", 32'(r_bcd), 32'd0);
`ifdef DIV_BCD_BLANK_EN
    check("rst_blank", 32'(q_blank), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Abort a conversion partway through.
    send(4321, 17);
    repeat (7) step();
    check("conv_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_q", 32'(q_bcd), 32'd0);
    check("abort_r", 32'(r_bcd), 32'd0);
    check("abort_in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    void'(sb.pop_back());
    send(999, 0);
    receive("after_abort", lat);

    // Zero conversion with latency and return to IDLE.
    send(0, 0);
    receive("zero", lat);
    check("zero_latency", 32'(lat), 32'd16);
    check("zero_in_ready_after", 32'(in_ready), 32'd1);
    check("zero_out_valid_after", 32'(out_valid), 32'd0);

    send(65535, 254);
    receive("max", lat);
    check("max_latency", 32'(lat), 32'd16);

    // Backpressure with ignored input during the stall.
    out_ready = 1'b0;
    send(1234, 56);
    for (int n = 0; n < 200 && !out_valid; n++) step();
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      result   = 16'd4321;
      odd      = 16'd9;
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_q", 32'(q_bcd), 32'h01234);
      check("bp_hold_r", 32'(r_bcd), 32'h00056);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    receive("bp", lat);
    repeat (20) step();
    check("bp_no_ghost", 32'(out_valid), 32'd0);
    check("bp_q_held", 32'(q_bcd), 32'h01234);

    // Random division results.
    for (int t = 0; t < 100; t++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(1, 255));
      send(a / b, a % b);
      receive("sweep", lat);
`ifdef DIV_BCD_BLANK_EN
      check("sweep_blank", 32'(q_blank), 32'(blank_model(a / b)));
`endif
    end

`ifdef DIV_BCD_BLANK_EN
    send(7, 0);
    receive("blank7", lat);
    check("blank_7", 32'(q_blank), 32'b11110);
    send(0, 0);
    receive("blank0", lat);
    check("blank_0", 32'(q_blank), 32'b11110);
    send(10000, 0);
    receive("blank10000", lat);
    check("blank_10000", 32'(q_blank), 32'b00000);
    send(305, 0);
    receive("blank305", lat);
    check("blank_305", 32'(q_blank), 32'b11000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
